aging_warning_collector: RTL and testbench

Consumer side of the aging-sensor monitors. It collects the per-cycle warning outputs of N_MON timing-margin monitors and synchronises them into the system clock domain. It counts warning cycles over a fixed evaluation window and compares the count against a programmable threshold. When the threshold is reached it latches an alarm and raises a req/ack handshake toward the DVFS/clock-scaling controller.

---
 rtl/aging_warning_collector.sv | 156 +++++++++++++++
 tb/tb_aging_warning_collector.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aging_warning_collector.sv
// aging_warning_collector
//   Collects per-cycle warning flags from N_MON aging/timing-margin monitors,
//   synchronises them into clk, counts warning cycles over a WIN_CYCLES
//   evaluation window, and compares the count against a programmable
//   threshold. A threshold hit latches a sticky alarm and raises a req/ack
//   handshake toward the DVFS/clock-scaling controller.
//
// Ports
//   clk, reset      system clock; asynchronous active-high reset
//   enable          level, 1 = run evaluation windows
//   warning_in      raw monitor warnings (asynchronous to clk)
//   thresh          alarm threshold in warning cycles, 0 = alarm disabled
//   alarm_clr       single-cycle pulse clearing aging_alarm
//   dvfs_ack        acknowledge from the DVFS controller
//   dvfs_req        scaling request, held until acknowledged
//   aging_alarm     sticky alarm
//   warn_count      warning-cycle count of the last completed window
//   fail_mask       monitors that warned in the last completed window
//   window_done     one-cycle pulse in the evaluation cycle

// Two-flop synchroniser for one monitor warning bit.
module aging_sync_lane (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module aging_warning_collector #(
  parameter int N_MON      = 8,
  parameter int CNT_W      = 8,
  parameter int WIN_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_MON-1:0] warning_in,
  input  logic [CNT_W-1:0] thresh,
  input  logic             alarm_clr,
  input  logic             dvfs_ack,
  output logic             dvfs_req,
  output logic             aging_alarm,
  output logic [CNT_W-1:0] warn_count,
  output logic [N_MON-1:0] fail_mask,
  output logic             window_done
);
  localparam int              WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MONITOR, EVAL, REQ} state_t;

  state_t           state, nxt;
  logic [N_MON-1:0] sync_w;
  logic             warn_any;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [N_MON-1:0] mask;
  logic             thr_hit;
  logic             eval_hit;

  // ---------------- per-monitor synchronisers
  genvar g;
  generate
    for (g = 0; g < N_MON; g++) begin : g_sync
      aging_sync_lane u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (warning_in[g]),
        .q     (sync_w[g])
      );
    end
  endgenerate

  assign warn_any = |sync_w;
  assign thr_hit  = (thresh != '0) && (err_cnt >= thresh);

  // ---------------- FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // ---------------- FSM: next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enable) nxt = MONITOR;
      // Dropping enable wins over window completion: a window that was not
      // fully enabled is never evaluated.
      MONITOR: if (!enable)                 nxt = IDLE;
               else if (win_cnt == WIN_LAST) nxt = EVAL;
      EVAL:    if (thr_hit)     nxt = REQ;
               else if (enable) nxt = MONITOR;
               else             nxt = IDLE;
      // The handshake always completes; enable only picks the exit.
      REQ:     if (dvfs_ack) nxt = enable ? MONITOR : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs
  always_comb begin
    window_done = (state == EVAL);
    eval_hit    = (state == EVAL) && thr_hit;
  end

  // ---------------- window counters
  // Counters only run in MONITOR and sit at zero elsewhere, so every entry
  // into MONITOR starts from a clean window. The EVAL-cycle sample is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      err_cnt <= '0;
      mask    <= '0;
    end else if (state == MONITOR) begin
      win_cnt <= win_cnt + 1'b1;
      if (warn_any && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      mask <= mask | sync_w;
    end else begin
      win_cnt <= '0;
      err_cnt <= '0;
      mask    <= '0;
    end
  end

  // ---------------- registered results and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvfs_req    <= 1'b0;
      aging_alarm <= 1'b0;
      warn_count  <= '0;
      fail_mask   <= '0;
    end else begin
      dvfs_req <= (nxt == REQ);
      if (state == EVAL) begin
        warn_count <= err_cnt;
        fail_mask  <= mask;
      end
      // A new hit beats a coincident clear.
      if (eval_hit)       aging_alarm <= 1'b1;
      else if (alarm_clr) aging_alarm <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aging_warning_collector.sv
module tb_aging_warning_collector;
  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int WIN  = 256;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  warning_in = '0;
  logic [CW-1:0] thresh = '0;
  logic          alarm_clr = 1'b0;
  logic          dvfs_ack = 1'b0;
  logic          dvfs_req, aging_alarm, window_done;
  logic [CW-1:0] warn_count;
  logic [N-1:0]  fail_mask;

  int checks = 0;
  int errors = 0;

  aging_warning_collector #(.N_MON(N), .CNT_W(CW), .WIN_CYCLES(WIN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .warning_in(warning_in),
    .thresh(thresh), .alarm_clr(alarm_clr), .dvfs_ack(dvfs_ack),
    .dvfs_req(dvfs_req), .aging_alarm(aging_alarm), .warn_count(warn_count),
    .fail_mask(fail_mask), .window_done(window_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model
  // m_pos: -1 = not sampling, 0..WIN-1 = samples taken so far in the window,
  // WIN = window complete (evaluation cycle). m_req tracks an open handshake.
  // d1/d2 carry the two-cycle input latency before a sample is visible.
  int           m_pos, m_cnt;
  logic [N-1:0] m_mask, m_fmask, d1, d2;
  logic [CW-1:0] m_count;
  logic         m_req, m_alarm;
  wire          m_done = (m_pos == WIN);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos <= -1; m_cnt <= 0; m_mask <= '0; m_fmask <= '0; m_count <= '0;
      m_req <= 1'b0; m_alarm <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      int pos, cnt;
      logic [N-1:0] msk;
      bit req, hit;
      pos = m_pos; cnt = m_cnt; msk = m_mask; req = m_req;
      hit = (thresh != 0) && (m_cnt >= int'(thresh));
      if (req) begin
        if (dvfs_ack) begin req = 1'b0; pos = enable ? 0 : -1; end
      end else if (pos < 0) begin
        if (enable) pos = 0;
      end else if (pos == WIN) begin
        m_count <= CW'(m_cnt);
        m_fmask <= m_mask;
        if (hit) begin req = 1'b1; pos = -1; end
        else pos = enable ? 0 : -1;
      end else if (!enable) begin
        pos = -1;
      end else begin
        if (d2 != 0 && cnt < MAXC) cnt++;
        msk |= d2;
        pos++;
      end
      if (pos == 0) begin cnt = 0; msk = '0; end
      if (m_pos == WIN && hit) m_alarm <= 1'b1;
      else if (alarm_clr)      m_alarm <= 1'b0;
      m_pos <= pos; m_cnt <= cnt; m_mask <= msk; m_req <= req;
      d2 <= d1; d1 <= warning_in;
    end
  end

  // ---------------- helpers (stimulus/timing only)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (window_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_warn(input logic [N-1:0] w, input int lead, input int len);
    ticks(lead);
    warning_in = w;
    ticks(len);
    warning_in = '0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({dvfs_req, aging_alarm, window_done, warn_count, fail_mask} !== '0) begin
      errors++;
      $display("FAIL reset_state req=%b alarm=%b done=%b cnt=%0d mask=%h expected all 0",
               dvfs_req, aging_alarm, window_done, warn_count, fail_mask);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_idle_windows();
    int last, pulses;
    bit bad_gap, bad_model, saw_req;
    enable = 1'b1; thresh = '0; warning_in = '0;
    last = 0; pulses = 0; bad_gap = 0; bad_model = 0; saw_req = 0;
    for (int i = 1; i <= 3 * (WIN + 1) + 3; i++) begin
      tick();
      if ({window_done, dvfs_req, aging_alarm, warn_count, fail_mask} !==
          {m_done, m_req, m_alarm, m_count, m_fmask}) bad_model = 1;
      if (dvfs_req) saw_req = 1;
      if (window_done) begin
        if (i - last != WIN + 1) bad_gap = 1;
        last = i; pulses++;
      end
    end
    checks++;
    if (pulses != 3 || bad_gap) begin
      errors++;
      $display("FAIL idle_done_period pulses=%0d gap_err=%b expected 3 pulses every %0d cycles",
               pulses, bad_gap, WIN + 1);
    end
    checks++;
    if (saw_req || warn_count !== 0 || fail_mask !== 0) begin
      errors++;
      $display("FAIL idle_results req_seen=%b cnt=%0d mask=%h expected 0/0/0",
               saw_req, warn_count, fail_mask);
    end
    checks++;
    if (bad_model) begin
      errors++;
      $display("FAIL idle_model got a per-cycle difference expected none");
    end
  endtask

  task automatic test_alarm_hit();
    bit ok, held;
    thresh = 8'd4;
    wait_done(600, ok);
    pulse_warn(8'h08, 30, 5);
    wait_done(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hit_timeout got no window_done expected one"); end
    tick();
    checks++;
    if ({warn_count, fail_mask, aging_alarm, dvfs_req} !== {8'd5, 8'h08, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hit_result cnt=%0d mask=%h alarm=%b req=%b expected 5/08/1/1",
               warn_count, fail_mask, aging_alarm, dvfs_req);
    end
    held = 1;
    for (int i = 0; i < 10; i++) begin tick(); if (dvfs_req !== 1'b1) held = 0; end
    checks++;
    if (!held) begin errors++; $display("FAIL hit_req_hold got drop before ack expected held"); end
    dvfs_ack = 1'b1;
    tick();
    dvfs_ack = 1'b0;
    checks++;
    if (dvfs_req !== 1'b0 || m_pos != 0) begin
      errors++;
      $display("FAIL hit_ack req=%b model_pos=%0d expected 0 and new window", dvfs_req, m_pos);
    end
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    checks++;
    if (aging_alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clear got %b expected 0", aging_alarm);
    end
  endtask

  task automatic test_below_thresh();
    bit ok;
    thresh = 8'd4;
    wait_done(600, ok);
    pulse_warn(8'h81, 20, 3);
    wait_done(600, ok);
    tick();
    checks++;
    if (!ok || {warn_count, fail_mask, aging_alarm, dvfs_req} !== {8'd3, 8'h81, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL below_thresh ok=%b cnt=%0d mask=%h alarm=%b req=%b expected 1/3/81/0/0",
               ok, warn_count, fail_mask, aging_alarm, dvfs_req);
    end
  endtask

  task automatic test_saturate();
    bit ok1, ok2;
    thresh = '0;
    warning_in = 8'hFF;
    wait_done(600, ok1);
    wait_done(600, ok2);
    tick();
    warning_in = '0;
    checks++;
    if (!(ok1 && ok2) || {warn_count, fail_mask, aging_alarm, dvfs_req} !==
        {8'd255, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL saturate ok=%b cnt=%0d mask=%h alarm=%b req=%b expected 1/255/ff/0/0",
               ok1 && ok2, warn_count, fail_mask, aging_alarm, dvfs_req);
    end
  endtask

  task automatic test_enable_drop();
    bit ok, held;
    int dones;
    logic [CW-1:0] pc;
    logic [N-1:0]  pm;
    thresh = 8'd4;
    wait_done(600, ok);
    tick();
    pc = m_count; pm = m_fmask;
    pulse_warn(8'h10, 40, 10);
    ticks(49);
    enable = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin tick(); if (window_done) dones++; end
    checks++;
    if (dones != 0 || warn_count !== pc || fail_mask !== pm || dvfs_req !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop dones=%0d cnt=%0d mask=%h req=%b expected 0/%0d/%h/0",
               dones, warn_count, fail_mask, dvfs_req, pc, pm);
    end
    enable = 1'b1;
    pulse_warn(8'h02, 20, 6);
    wait_done(600, ok);
    tick();
    checks++;
    if (!ok || dvfs_req !== 1'b1) begin
      errors++;
      $display("FAIL req_open ok=%b req=%b expected 1/1", ok, dvfs_req);
    end
    enable = 1'b0;
    held = 1;
    for (int i = 0; i < 5; i++) begin tick(); if (dvfs_req !== 1'b1) held = 0; end
    checks++;
    if (!held) begin errors++; $display("FAIL req_no_abort got drop expected held with enable=0"); end
    dvfs_ack = 1'b1;
    tick();
    dvfs_ack = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin tick(); if (window_done) dones++; end
    checks++;
    if (dvfs_req !== 1'b0 || dones != 0 || m_pos != -1) begin
      errors++;
      $display("FAIL req_to_idle req=%b dones=%0d expected 0/0", dvfs_req, dones);
    end
  endtask

  task automatic test_async_reset_and_set_wins();
    bit ok;
    enable = 1'b1; thresh = 8'd4;
    pulse_warn(8'h40, 20, 6);
    wait_done(600, ok);
    tick();
    checks++;
    if (dvfs_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req got %b expected 1", dvfs_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dvfs_req, aging_alarm, window_done, warn_count, fail_mask} !== '0) begin
      errors++;
      $display("FAIL async_reset req=%b alarm=%b cnt=%0d mask=%h expected all 0",
               dvfs_req, aging_alarm, warn_count, fail_mask);
    end
    tick();
    reset = 1'b0;
    pulse_warn(8'h04, 20, 6);
    wait_done(600, ok);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    checks++;
    if (aging_alarm !== 1'b1 || dvfs_req !== 1'b1) begin
      errors++;
      $display("FAIL set_wins alarm=%b req=%b expected 1/1", aging_alarm, dvfs_req);
    end
    dvfs_ack = 1'b1;
    tick();
    dvfs_ack = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      checks++;
      if ({window_done, dvfs_req, aging_alarm, warn_count, fail_mask} !==
          {m_done, m_req, m_alarm, m_count, m_fmask}) begin
        errors++;
        if (bad < 5)
          $display("FAIL random_model t=%0t got done=%b req=%b alarm=%b cnt=%0d mask=%h expected done=%b req=%b alarm=%b cnt=%0d mask=%h",
                   $time, window_done, dvfs_req, aging_alarm, warn_count, fail_mask,
                   m_done, m_req, m_alarm, m_count, m_fmask);
        bad++;
      end
      warning_in = ($urandom_range(0, 59) == 0) ? N'($urandom) : '0;
      dvfs_ack   = ($urandom_range(0, 3) == 0);
      alarm_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) thresh = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end
  endtask

  initial begin
    test_reset();
    test_idle_windows();
    test_alarm_hit();
    test_below_thresh();
    test_saturate();
    test_enable_drop();
    test_async_reset_and_set_wins();
    enable = 1'b1;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
